// File: rtl/branch_resolve_queue_pkg.sv
// Shared types for the branch resolution queue: resolution packet, queue entry, sizing constants.
`ifndef B_MASK_WIDTH
`define B_MASK_WIDTH 8
`endif

package branch_resolve_queue_pkg;
  localparam int B_MASK_W  = `B_MASK_WIDTH;
  localparam int BR_FU     = 2;
  localparam int BRQ_DEPTH = 4;

  typedef logic [B_MASK_W-1:0] B_MASK;

  typedef struct packed {
    B_MASK       b_mm;
    logic        bm_mispred;
    logic [31:0] result;
    logic        taken;
  } BRANCH_REG_PACKET;

  typedef struct packed {
    logic             valid;
    BRANCH_REG_PACKET packet;
    B_MASK            dep_mask;
  } BRQ_ENTRY;
endpackage

// File: rtl/branch_resolve_queue_pick.sv
// Combinational picker: oldest mispredict first (by dep_mask), else lowest index.
module brq_pick import branch_resolve_queue_pkg::*; #(
  parameter int N = 6
) (
  input  logic [N-1:0]  cand_vld_i,
  input  logic [N-1:0]  cand_mp_i,
  input  B_MASK [N-1:0] cand_bmm_i,
  input  B_MASK [N-1:0] cand_dep_i,
  output logic [N-1:0]  sel_o
);
  logic [N-1:0] mp_vld, oldest, req;
  B_MASK        mp_tags;

  always_comb begin
    mp_vld  = cand_vld_i & cand_mp_i;
    mp_tags = '0;
    for (int i = 0; i < N; i++)
      if (mp_vld[i]) mp_tags = mp_tags | cand_bmm_i[i];
    // A mispredict is oldest when it depends on no other live mispredict.
    for (int i = 0; i < N; i++)
      oldest[i] = mp_vld[i] && ((cand_dep_i[i] & mp_tags & ~cand_bmm_i[i]) == '0);
    if (|oldest)      req = oldest;
    else if (|mp_vld) req = mp_vld;
    else              req = cand_vld_i;
    sel_o = req & (-req);
  end
endmodule

// File: rtl/branch_resolve_queue.sv
// Branch resolution queue: buffers execute resolutions, issues one per cycle, mispredicts first.
module branch_resolve_queue import branch_resolve_queue_pkg::*; #(
  parameter int BR_FU        = branch_resolve_queue_pkg::BR_FU,
  parameter int DEPTH        = BRQ_DEPTH,
  parameter int B_MASK_WIDTH = `B_MASK_WIDTH,
  parameter bit HS_CHECK     = 1'b1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [BR_FU-1:0]                    br_valid,
  input  BRANCH_REG_PACKET [BR_FU-1:0]        br_packet,
  input  logic [BR_FU-1:0][B_MASK_WIDTH-1:0]  br_dep_mask,
  output logic                                br_ready,
  output logic                                brq_out_valid,
  output BRANCH_REG_PACKET                    branch_completing,
  output logic [$clog2(DEPTH+1)-1:0]          brq_count
);
  localparam int N  = DEPTH + BR_FU;
  localparam int CW = $clog2(DEPTH+1);

  BRQ_ENTRY [DEPTH-1:0] ent_q, ent_d;
  BRANCH_REG_PACKET     out_q, out_d;
  logic                 out_vld_q, out_vld_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  B_MASK                     kill_m, clr_m;
  logic [N-1:0]              c_vld, c_mp, sel;
  B_MASK [N-1:0]             c_bmm, c_dep;
  BRANCH_REG_PACKET [N-1:0]  c_pkt;
  logic                      placed;

  assign br_ready = (DEPTH - int'(cnt_q)) >= BR_FU;

  // Kill/clear use the resolution the branch stack consumes this same cycle.
  always_comb begin
    kill_m = out_q.bm_mispred ? out_q.b_mm : '0;
    clr_m  = out_q.b_mm;
    for (int q = 0; q < DEPTH; q++) begin
      c_vld[q] = ent_q[q].valid && ((ent_q[q].dep_mask & kill_m) == '0);
      c_pkt[q] = ent_q[q].packet;
      c_dep[q] = ent_q[q].dep_mask & ~clr_m;
      c_mp[q]  = ent_q[q].packet.bm_mispred;
      c_bmm[q] = ent_q[q].packet.b_mm;
    end
    for (int l = 0; l < BR_FU; l++) begin
      c_vld[DEPTH+l] = br_valid[l] && br_ready && ((br_dep_mask[l] & kill_m) == '0);
      c_pkt[DEPTH+l] = br_packet[l];
      c_dep[DEPTH+l] = br_dep_mask[l] & ~clr_m;
      c_mp[DEPTH+l]  = br_packet[l].bm_mispred;
      c_bmm[DEPTH+l] = br_packet[l].b_mm;
    end
  end

  brq_pick #(.N(N)) u_pick (
    .cand_vld_i (c_vld),
    .cand_mp_i  (c_mp),
    .cand_bmm_i (c_bmm),
    .cand_dep_i (c_dep),
    .sel_o      (sel)
  );

  always_comb begin
    out_d     = '0;
    out_vld_d = |sel;
    placed    = 1'b0;
    for (int i = 0; i < N; i++)
      if (sel[i]) out_d = c_pkt[i];
    for (int q = 0; q < DEPTH; q++) begin
      ent_d[q] = '0;
      if (c_vld[q] && !sel[q])
        ent_d[q] = '{valid: 1'b1, packet: c_pkt[q], dep_mask: c_dep[q]};
    end
    // Slots freed by this cycle's pick are reusable immediately.
    for (int l = 0; l < BR_FU; l++) begin
      placed = 1'b0;
      if (c_vld[DEPTH+l] && !sel[DEPTH+l]) begin
        for (int q = 0; q < DEPTH; q++) begin
          if (!placed && !ent_d[q].valid) begin
            ent_d[q] = '{valid: 1'b1, packet: c_pkt[DEPTH+l], dep_mask: c_dep[DEPTH+l]};
            placed   = 1'b1;
          end
        end
      end
    end
    cnt_d = '0;
    for (int q = 0; q < DEPTH; q++)
      cnt_d = cnt_d + CW'(ent_d[q].valid);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ent_q     <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ent_q     <= ent_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      cnt_q     <= cnt_d;
    end
  end

  assign brq_out_valid     = out_vld_q;
  assign branch_completing = out_q;
  assign brq_count         = cnt_q;

  if (HS_CHECK) begin : g_hs_chk
    always_ff @(posedge clock)
      if (!reset)
        assert (!(|br_valid) || br_ready)
          else $error("brq: br_valid asserted while br_ready=0");
  end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue with an in-order scoreboard of expected issues.
module tb_branch_resolve_queue;
  import branch_resolve_queue_pkg::*;

  localparam int NL = 2;
  localparam int D  = 4;
  localparam int MW = B_MASK_W;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NL-1:0]                br_valid;
  BRANCH_REG_PACKET [NL-1:0]    br_packet;
  logic [NL-1:0][MW-1:0]        br_dep_mask;
  logic                         br_ready;
  logic                         brq_out_valid;
  BRANCH_REG_PACKET             branch_completing;
  logic [$clog2(D+1)-1:0]       brq_count;

  int checks = 0;
  int failures = 0;
  BRANCH_REG_PACKET exp_q[$];

  always #5 clock = ~clock;

  branch_resolve_queue #(.BR_FU(NL), .DEPTH(D), .B_MASK_WIDTH(MW), .HS_CHECK(1'b0)) dut (
    .clock             (clock),
    .reset             (reset),
    .br_valid          (br_valid),
    .br_packet         (br_packet),
    .br_dep_mask       (br_dep_mask),
    .br_ready          (br_ready),
    .brq_out_valid     (brq_out_valid),
    .branch_completing (branch_completing),
    .brq_count         (brq_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  function automatic BRANCH_REG_PACKET mk(input logic [MW-1:0] bmm, input logic mp);
    BRANCH_REG_PACKET p;
    p            = '0;
    p.b_mm       = bmm;
    p.bm_mispred = mp;
    p.result     = 32'hB0C0_0000 | 32'(bmm);
    p.taken      = ~mp ^ bmm[0];
    return p;
  endfunction

  task automatic lane(input int l, input logic [MW-1:0] bmm, input logic mp, input logic [MW-1:0] dep);
    br_valid[l]    = 1'b1;
    br_packet[l]   = mk(bmm, mp);
    br_dep_mask[l] = dep;
  endtask

  task automatic expect_out(input logic [MW-1:0] bmm, input logic mp);
    exp_q.push_back(mk(bmm, mp));
  endtask

  task automatic idle();
    br_valid    = '0;
    br_packet   = '0;
    br_dep_mask = '0;
  endtask

  // Advance one cycle and let the scoreboard judge whatever the DUT issued.
  task automatic tick();
    BRANCH_REG_PACKET e;
    @(posedge clock);
    #1;
    if (brq_out_valid) begin
      if (exp_q.size() == 0)
        chk("out_unexpected", 64'(branch_completing), 64'h0);
      else begin
        e = exp_q.pop_front();
        chk("out_pkt", 64'(branch_completing), 64'(e));
      end
    end else
      chk("idle_zero", 64'(branch_completing), 64'h0);
  endtask

  initial begin
    idle();
    tick();
    tick();
    reset = 1'b0;
    chk("rst_valid", 64'(brq_out_valid), 64'h0);
    chk("rst_count", 64'(brq_count), 64'h0);
    chk("rst_ready", 64'(br_ready), 64'h1);

    // Single correct predict.
    lane(0, 8'h01, 1'b0, 8'h00); expect_out(8'h01, 1'b0);
    tick(); chk("t1_valid", 64'(brq_out_valid), 64'h1);
    idle();
    tick(); chk("t1_after", 64'(brq_out_valid), 64'h0);

    // Two correct predicts together.
    lane(0, 8'h01, 1'b0, 8'h00); lane(1, 8'h02, 1'b0, 8'h00);
    expect_out(8'h01, 1'b0); expect_out(8'h02, 1'b0);
    tick(); chk("t2_valid0", 64'(brq_out_valid), 64'h1); chk("t2_count1", 64'(brq_count), 64'h1);
    idle();
    tick(); chk("t2_valid1", 64'(brq_out_valid), 64'h1); chk("t2_count0", 64'(brq_count), 64'h0);
    tick();

    // Mispredict priority, queued 04 independent of the mispredict.
    lane(0, 8'h02, 1'b0, 8'h00); lane(1, 8'h04, 1'b0, 8'h00); expect_out(8'h02, 1'b0);
    tick(); idle();
    lane(0, 8'h01, 1'b1, 8'h00); expect_out(8'h01, 1'b1); expect_out(8'h04, 1'b0);
    tick(); idle(); chk("t3a_count", 64'(brq_count), 64'h1);
    tick(); chk("t3a_valid", 64'(brq_out_valid), 64'h1);
    tick();

    // Mispredict priority, queued 04 depends on the mispredict and is dropped.
    lane(0, 8'h02, 1'b0, 8'h00); lane(1, 8'h04, 1'b0, 8'h01); expect_out(8'h02, 1'b0);
    tick(); idle();
    lane(0, 8'h01, 1'b1, 8'h00); expect_out(8'h01, 1'b1);
    tick(); idle(); chk("t3b_valid", 64'(brq_out_valid), 64'h1);
    tick(); chk("t3b_count", 64'(brq_count), 64'h0); chk("t3b_killed", 64'(brq_out_valid), 64'h0);

    // Oldest mispredict sits on the higher lane; the younger one must be killed.
    lane(0, 8'h02, 1'b1, 8'h01); lane(1, 8'h01, 1'b1, 8'h00); expect_out(8'h01, 1'b1);
    tick(); idle(); chk("t4_count", 64'(brq_count), 64'h1);
    tick(); chk("t4_killed", 64'(brq_out_valid), 64'h0); chk("t4_count0", 64'(brq_count), 64'h0);

    // Mispredict in O kills a dependent same-cycle bypass candidate.
    lane(0, 8'h01, 1'b1, 8'h00); expect_out(8'h01, 1'b1);
    tick(); idle();
    lane(0, 8'h04, 1'b0, 8'h01); lane(1, 8'h08, 1'b0, 8'h00); expect_out(8'h08, 1'b0);
    tick(); idle(); chk("t5_count", 64'(brq_count), 64'h0);
    tick();

    // Fill to 3 queued; illegal held inputs are ignored; drain restores ready.
    lane(0, 8'h01, 1'b0, 8'h00); lane(1, 8'h02, 1'b0, 8'h00);
    expect_out(8'h01, 1'b0); expect_out(8'h02, 1'b0);
    tick(); chk("f_cnt1", 64'(brq_count), 64'h1); chk("f_rdy1", 64'(br_ready), 64'h1);
    lane(0, 8'h04, 1'b0, 8'h00); lane(1, 8'h08, 1'b0, 8'h00); expect_out(8'h04, 1'b0);
    tick(); chk("f_cnt2", 64'(brq_count), 64'h2); chk("f_rdy2", 64'(br_ready), 64'h1);
    lane(0, 8'h10, 1'b0, 8'h00); lane(1, 8'h20, 1'b0, 8'h00);
    expect_out(8'h10, 1'b0); expect_out(8'h08, 1'b0); expect_out(8'h20, 1'b0);
    tick(); chk("f_cnt3", 64'(brq_count), 64'h3); chk("f_rdy3", 64'(br_ready), 64'h0);
    lane(0, 8'h40, 1'b0, 8'h00); lane(1, 8'h80, 1'b0, 8'h00);
    tick(); idle(); chk("f_ign_cnt", 64'(brq_count), 64'h2); chk("f_rdy_back", 64'(br_ready), 64'h1);
    tick(); chk("f_drain1", 64'(brq_count), 64'h1);
    tick(); chk("f_drain0", 64'(brq_count), 64'h0);
    tick(); tick();

    // Reset with three queued entries and O valid.
    lane(0, 8'h01, 1'b0, 8'h00); lane(1, 8'h02, 1'b0, 8'h00); expect_out(8'h01, 1'b0);
    tick();
    lane(0, 8'h04, 1'b0, 8'h00); lane(1, 8'h08, 1'b0, 8'h00); expect_out(8'h02, 1'b0);
    tick();
    lane(0, 8'h10, 1'b0, 8'h00); lane(1, 8'h20, 1'b0, 8'h00); expect_out(8'h04, 1'b0);
    tick(); idle();
    chk("r_pre_cnt", 64'(brq_count), 64'h3); chk("r_pre_vld", 64'(brq_out_valid), 64'h1);
    reset = 1'b1;
    tick();
    chk("r_valid", 64'(brq_out_valid), 64'h0);
    chk("r_pkt", 64'(branch_completing), 64'h0);
    chk("r_count", 64'(brq_count), 64'h0);
    chk("r_ready", 64'(br_ready), 64'h1);
    reset = 1'b0;
    tick(); tick(); tick();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("sb_empty", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

Buffers branch resolutions from the execute-stage branch units and issues at most one resolution per cycle to the branch stack. It gives mispredictions priority and discards queued resolutions of branches that a just-issued mispredict has squashed. It sits between the execute/complete stage and the branch stack; its output register is the branch stack's resolution input.

## Interface

**Parameters**
- `BR_FU`, default 2: branch units reporting per cycle.
- `DEPTH`, default 4: queue entries; `DEPTH >= BR_FU`.
- `B_MASK_WIDTH`, default `` `B_MASK_WIDTH ``: branch-mask width.

**Ports** (clock and reset first)
- `clock`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `br_valid`  in  `BR_FU`: resolution present on a branch unit.
- `br_packet`  in  `BR_FU` x `BRANCH_REG_PACKET`: resolution payload.
  - `b_mm` is one-hot.
  - Fields: `bm_mispred`, `result`, `taken`.
- `br_dep_mask`  in  `BR_FU` x `B_MASK`: older branches the resolving branch depends on.
- `br_ready`  out  1: all `BR_FU` units may present this cycle.
- `brq_out_valid`  out  1: `branch_completing` carries a resolution.
- `branch_completing`  out  `BRANCH_REG_PACKET`: registered resolution to the branch stack.
  - All-zero whenever `brq_out_valid` = 0, so `b_mm` = 0 means no action.
- `brq_count`  out  `$clog2(DEPTH+1)`: occupied entries (debug/perf).

## Operation

**Entry contents:** valid, packet, dep_mask.

**Cycle step** (let O = the current output register and M = `O.b_mm` when `O.bm_mispred` = 1, else 0):
1. **Kill.** Drop every queued entry and every incoming resolution with `(dep_mask & M) != 0`.
2. **Clear.** Clear bit `O.b_mm` from the dep_mask of all survivors, for correct and mispredicted resolutions alike. Resolved branches then no longer gate younger ones.
3. **Candidates.** Surviving queued entries plus surviving incoming `br_valid` lanes (bypass).
4. **Pick, stage 1.** If any candidate has `bm_mispred`, choose the oldest mispredict: the one whose dep_mask contains no other mispredict candidate's `b_mm`. Break ties by queue index before lane index, lowest first.
5. **Pick, stage 2.** Otherwise choose the lowest queue index, then the lowest lane.
6. **Load.** Load the chosen candidate into O, with the kill and clear rules already applied to its dep_mask. If there is no candidate, O is all-zero and valid is 0.
7. **Enqueue.** Unchosen surviving incoming lanes enqueue into the lowest free slots in lane order. Slot order carries no age meaning.

**Handshake**
- `br_ready` = (`DEPTH` − registered count) >= `BR_FU`, computed from registered state only.
- Execute must not assert `br_valid` while `br_ready` = 0. Such inputs are ignored. An assertion flags this.
- Once accepted, a resolution is never lost unless it is killed.

**Boundaries**
- Queue full: `br_ready` = 0; the queue still issues one per cycle.
- A mispredict in O kills the same-cycle bypass candidates that depend on it.
- The resolution in O is never itself killed.
- Duplicate `b_mm` across live entries is illegal. Dispatch guarantees uniqueness.

## Timing

- **Latency:** execute resolution in cycle t; `branch_completing` valid at t+1 at best. A queued entry waits at least one more cycle per older pick.
- **Throughput:** 1 resolution/cycle.
- **Kill timing:** kill and clear use O from the same cycle the branch stack consumes it. A squashed entry therefore never reaches the output.
- **Reset:**
  - all entries invalid;
  - `brq_out_valid` = 0 and `branch_completing` = 0;
  - `brq_count` = 0;
  - `br_ready` = 1 the following cycle.
- **Mid-operation reset:** drops all pending resolutions with no output.

## Structure

- **Shared package additions:**
  - `BRQ_ENTRY` typedef (valid, `BRANCH_REG_PACKET`, `B_MASK` dep_mask);
  - `BRQ_DEPTH` constant;
  - `BR_FU` constant.
- **Sub-module `brq_pick`:** combinational candidate picker over `DEPTH+BR_FU` inputs. It returns a one-hot select using mispredict-first, oldest-mispredict-by-dep-mask, then lowest-index priority.
- **Top level:** holds the entry array, output register, count and `br_ready` logic.

## Test plan

- **Single correct predict:** lane0 `b_mm`=0001, mispred=0.
  - t+1: `brq_out_valid`=1, `b_mm`=0001.
  - t+2: output all-zero.
- **Two correct predicts in one cycle:** lane0=0001, lane1=0010.
  - Output is 0001 at t+1, then 0010 at t+2.
  - `brq_count` is 1 at t+1.
- **Mispredict priority:** queue holds correct 0100. Incoming is mispredict 0001.
  - t+1 output is 0001 mispred.
  - 0100 issues at t+2 only if its dep_mask & 0001 = 0; otherwise it is dropped and `brq_count` = 0.
- **Oldest mispredict:** two mispredicts in one cycle, A `b_mm`=0001 dep=0000, B `b_mm`=0010 dep=0001.
  - A issues.
  - B is killed the next cycle; it never appears on the output.
- **Full:** `DEPTH`=4, fill so that `brq_count`=3.
  - `br_ready`=0 whenever count > 2.
  - `br_valid` held with `br_ready`=0 has no effect.
  - Draining returns `br_ready`=1 once count <= 2.
- **Reset mid-operation:** assert reset with 3 queued entries and O valid.
  - Next cycle: `brq_out_valid`=0, `branch_completing`=0, `brq_count`=0, `br_ready`=1.
